uart_rx_hex_monitor: RTL



---
 rtl/uart_rx_hex_monitor_if.sv | 27 ++
 rtl/uart_rx_hex_monitor.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_hex_monitor_if.sv
// Signal bundle for the passive UART monitor. The tapped serial line goes in.
// The byte strobe bus and the six 7-segment digit drives come out.
interface uart_rx_hex_monitor_if;
  logic       rxd;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       frame_err;
  logic [7:0] hex0;
  logic [7:0] hex1;
  logic [7:0] hex2;
  logic [7:0] hex3;
  logic [7:0] hex4;
  logic [7:0] hex5;

  // The monitor itself is the slave: it samples rxd and drives everything else.
  modport slave (
    input  rxd,
    output byte_data, byte_valid, frame_err,
    output hex0, hex1, hex2, hex3, hex4, hex5
  );

  modport master (
    output rxd,
    input  byte_data, byte_valid, frame_err,
    input  hex0, hex1, hex2, hex3, hex4, hex5
  );
endinterface

// File: rtl/uart_rx_hex_monitor.sv
// Passive 8N1 receiver tapping the CPU board TXD line. It shows the last three
// bytes as hex on six active-low 7-segment digits and strobes each byte out.
module uart_rx_hex_monitor #(
  parameter int SYSCLK_MHZ = 50,
  parameter int BAUD_RATE  = 115200
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_rx_hex_monitor_if.slave  mon
);

  localparam int BIT_TICKS  = SYSCLK_MHZ * 1000000 / BAUD_RATE;
  localparam int HALF_TICKS = BIT_TICKS / 2;
  localparam logic [15:0] BIT_LOAD  = 16'(BIT_TICKS - 1);
  localparam logic [15:0] HALF_LOAD = 16'(HALF_TICKS - 1);
  localparam logic [7:0]  HEX_DASH  = 8'hBF;

  if (BIT_TICKS < 4 || BIT_TICKS > 65535) begin : g_bad_baud
    $error("uart_rx_hex_monitor: BIT_TICKS out of range 4..65535");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t      state_reg;
  logic [15:0] cnt_reg;
  logic [2:0]  idx_reg;
  logic [7:0]  shift_reg;
  logic [7:0]  byte_data_reg;
  logic        byte_valid_reg;
  logic        frame_err_reg;
  logic        rx_meta_reg;
  logic        rx_sync_reg;

  logic        tick;
  logic        stop_ok;
  logic        stop_bad;

  logic [7:0]  slot_data_reg   [3];
  logic        slot_valid_reg  [3];
  logic [7:0]  slot_data_next  [3];
  logic        slot_valid_next [3];
  logic        err_dp_reg;
  logic        err_dp_next;
  logic [7:0]  hex_reg  [6];
  logic [7:0]  hex_next [6];

  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      4'hF: seg = 8'h8E;
    endcase
    return seg;
  endfunction

  // The tapped line is fully asynchronous; it idles high, so reset to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
    end else begin
      rx_meta_reg <= mon.rxd;
      rx_sync_reg <= rx_meta_reg;
    end
  end

  assign tick     = (cnt_reg == 16'd0);
  assign stop_ok  = (state_reg == ST_STOP) && tick &&  rx_sync_reg;
  assign stop_bad = (state_reg == ST_STOP) && tick && !rx_sync_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      shift_reg      <= '0;
      byte_data_reg  <= '0;
      byte_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      byte_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (!rx_sync_reg) begin
            cnt_reg   <= HALF_LOAD;
            state_reg <= ST_START;
          end
        end
        ST_START: begin
          if (!tick) begin
            cnt_reg <= cnt_reg - 16'd1;
          end else if (rx_sync_reg) begin
            // Start bit did not survive to mid-bit: a glitch, not a frame.
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg   <= BIT_LOAD;
            idx_reg   <= '0;
            state_reg <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (!tick) begin
            cnt_reg <= cnt_reg - 16'd1;
          end else begin
            shift_reg <= {rx_sync_reg, shift_reg[7:1]};
            cnt_reg   <= BIT_LOAD;
            if (idx_reg == 3'd7) begin
              state_reg <= ST_STOP;
            end else begin
              idx_reg <= idx_reg + 3'd1;
            end
          end
        end
        ST_STOP: begin
          if (!tick) begin
            cnt_reg <= cnt_reg - 16'd1;
          end else if (rx_sync_reg) begin
            byte_data_reg  <= shift_reg;
            byte_valid_reg <= 1'b1;
            state_reg      <= ST_IDLE;
          end else begin
            frame_err_reg <= 1'b1;
            state_reg     <= ST_BREAK;
          end
        end
        ST_BREAK: begin
          if (rx_sync_reg) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Display history is decoded from next-state values so the digits move on
  // the same edge that raises byte_valid.
  for (genvar gi = 0; gi < 3; gi++) begin : g_slot
    if (gi == 0) begin : g_head
      assign slot_data_next[gi]  = stop_ok ? shift_reg : slot_data_reg[gi];
      assign slot_valid_next[gi] = stop_ok ? 1'b1      : slot_valid_reg[gi];
    end else begin : g_tail
      assign slot_data_next[gi]  = stop_ok ? slot_data_reg[gi-1]  : slot_data_reg[gi];
      assign slot_valid_next[gi] = stop_ok ? slot_valid_reg[gi-1] : slot_valid_reg[gi];
    end
    assign hex_next[2*gi]   = slot_valid_next[gi] ? seg_decode(slot_data_next[gi][3:0]) : HEX_DASH;
    assign hex_next[2*gi+1] = slot_valid_next[gi] ? seg_decode(slot_data_next[gi][7:4]) : HEX_DASH;
  end

  assign err_dp_next = stop_bad ? 1'b1 : (stop_ok ? 1'b0 : err_dp_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_dp_reg <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        slot_data_reg[i]  <= '0;
        slot_valid_reg[i] <= 1'b0;
      end
      for (int i = 0; i < 6; i++) begin
        hex_reg[i] <= HEX_DASH;
      end
    end else begin
      err_dp_reg <= err_dp_next;
      for (int i = 0; i < 3; i++) begin
        slot_data_reg[i]  <= slot_data_next[i];
        slot_valid_reg[i] <= slot_valid_next[i];
      end
      // HEX0's dp is the sticky framing-error lamp, overlaid on whatever digit shows.
      hex_reg[0] <= {hex_next[0][7] & ~err_dp_next, hex_next[0][6:0]};
      for (int i = 1; i < 6; i++) begin
        hex_reg[i] <= hex_next[i];
      end
    end
  end

  assign mon.byte_data  = byte_data_reg;
  assign mon.byte_valid = byte_valid_reg;
  assign mon.frame_err  = frame_err_reg;
  assign mon.hex0       = hex_reg[0];
  assign mon.hex1       = hex_reg[1];
  assign mon.hex2       = hex_reg[2];
  assign mon.hex3       = hex_reg[3];
  assign mon.hex4       = hex_reg[4];
  assign mon.hex5       = hex_reg[5];

endmodule
